// File: rtl/fp_dec_pkg.sv
// Shared types and defaults for the float-to-decimal conversion path.
package fp_dec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_t;

    localparam int WIDTH_DEF  = 24;
    localparam int DIGITS_DEF = 8;
    localparam int CNT_W      = $clog2(WIDTH_DEF);

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: any digit of 5 or more gets +3 before the shift.
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bcd_convert_seq.sv
// Iterative binary-to-BCD converter, one magnitude bit per clock, with
// valid/ready handshakes on both sides and one conversion in flight.
module bcd_convert_seq
    import fp_dec_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH:0]      in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [4*DIGITS-1:0] bcd,
    output logic                sign,
    output logic [3:0]          ndig,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    conv_state_t         state;
    logic [CW-1:0]       cnt;
    logic [WIDTH-1:0]    mag;
    logic [4*DIGITS-1:0] acc;
    logic [4*DIGITS-1:0] acc_fix;
    logic [4*DIGITS-1:0] acc_next;
    logic [WIDTH-1:0]    mag_next;
    logic [3:0]          ndig_next;

    for (genvar g = 0; g < DIGITS; g++) begin : g_fix
        bcd_add3 u_add3 (
            .d(acc[4*g +: 4]),
            .q(acc_fix[4*g +: 4])
        );
    end

    // The magnitude MSB shifts into the corrected BCD accumulator each step.
    assign {acc_next, mag_next} = {acc_fix, mag} << 1;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        ndig_next = 4'd1;
        for (int i = 1; i < DIGITS; i++) begin
            if (acc_next[4*i +: 4] != 4'd0) begin
                ndig_next = 4'(i + 1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            cnt       <= '0;
            mag       <= '0;
            acc       <= '0;
            bcd       <= '0;
            sign      <= 1'b0;
            ndig      <= 4'd1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is registered, so it first rises one edge after reset release.
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        mag      <= in[WIDTH-1:0];
                        sign     <= in[WIDTH];
                        acc      <= '0;
                        cnt      <= CW'(WIDTH - 1);
                        in_ready <= 1'b0;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    acc <= acc_next;
                    mag <= mag_next;
                    if (cnt == '0) begin
                        bcd       <= acc_next;
                        ndig      <= ndig_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Directed bench for bcd_convert_seq: hand-computed BCD results, latency,
// back-pressure, mid-conversion reset and back-to-back transfers.
module tb_bcd_convert_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [24:0] din;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] bcd;
    logic        sign;
    logic [3:0]  ndig;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;
    int lat;

    bcd_convert_seq #(.WIDTH(24), .DIGITS(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (din),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bcd      (bcd),
        .sign     (sign),
        .ndig     (ndig),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a word and hold in_valid until the accept edge has passed.
    task automatic do_accept(input logic [24:0] v);
        int n = 0;
        @(negedge clk);
        din      = v;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges from the accept edge until out_valid appears.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("take_valid_low", 32'(out_valid), 32'd0);
    endtask

    task automatic convert(input string tag, input logic [24:0] v,
                           input logic [31:0] exp_bcd, input logic exp_sign,
                           input logic [3:0] exp_ndig);
        do_accept(v);
        wait_valid(lat);
        check({tag, "_lat"}, 32'(lat), 32'd24);
        check({tag, "_bcd"}, bcd, exp_bcd);
        check({tag, "_sign"}, 32'(sign), 32'(exp_sign));
        check({tag, "_ndig"}, 32'(ndig), 32'(exp_ndig));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b1;
        din       = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_bcd", bcd, 32'h0);
        check("rst_sign", 32'(sign), 32'd0);
        check("rst_ndig", 32'(ndig), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        convert("zero", {1'b0, 24'h0}, 32'h00000000, 1'b0, 4'd1);
        take();
        convert("max", {1'b0, 24'hFFFFFF}, 32'h16777215, 1'b0, 4'd8);
        take();
        convert("neg", {1'b1, 24'd12345}, 32'h00012345, 1'b1, 4'd5);
        take();

        // Back-pressure: result must hold and foreign inputs must be ignored.
        convert("hold", {1'b0, 24'd4096}, 32'h00004096, 1'b0, 4'd4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            din      = {1'b1, 24'd777};
            in_valid = (i % 2 == 0);
            check("hold_bcd", bcd, 32'h00004096);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        check("hold_sign", 32'(sign), 32'd0);
        check("hold_ndig", 32'(ndig), 32'd4);
        take();
        repeat (3) @(posedge clk);
        #1;
        check("after_keep_bcd", bcd, 32'h00004096);
        check("after_no_conv", 32'(out_valid), 32'd0);

        // Reset in the middle of a conversion.
        do_accept({1'b0, 24'd5555});
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_bcd", bcd, 32'h0);
        check("midrst_ndig", 32'(ndig), 32'd1);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        convert("post_rst", {1'b0, 24'd999}, 32'h00000999, 1'b0, 4'd3);
        take();

        // Back-to-back: second accept on the edge after the first handshake.
        convert("b2b_a", {1'b0, 24'd1}, 32'h00000001, 1'b0, 4'd1);
        @(negedge clk);
        out_ready = 1'b1;
        din       = {1'b0, 24'd10000000};
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_hs_valid", 32'(out_valid), 32'd0);
        check("b2b_hs_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("b2b_accepted", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        wait_valid(lat);
        check("b2b_b_lat", 32'(lat), 32'd24);
        check("b2b_b_bcd", bcd, 32'h10000000);
        check("b2b_b_ndig", 32'(ndig), 32'd8);
        take();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
